// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings and data/word widths.
// Word width grows to 9 bits when DMEM_PARITY_EN is defined.
package dmem_ctrl_pkg;

   localparam int DATA_W = 8;

`ifdef DMEM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_DONE = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl_array.sv
// dmem_array: storage only. Synchronous write, registered read on commit enable.
// The read register clears on reset; the storage itself is never reset.
module dmem_array
   import dmem_ctrl_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic              zero,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wword,
   output logic [WORD_W-1:0] rword
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wword;
   end

   // Out-of-range reads load zero so rdata and parity both come back clean.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rword <= '0;
      else if (re) rword <= zero ? '0 : mem[idx];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: latches one request, waits WAIT_STATES cycles, commits, then acks.
// Optional per-word parity is enabled by defining DMEM_PARITY_EN.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              busy,
   output logic              par_err,
   output dmem_state_e       dbg_state
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Handshake: req/we/addr/wdata are sampled only on an edge where the FSM is IDLE;
   // ack is a one-cycle pulse, busy is high whenever the FSM is not IDLE.
   dmem_state_e       state;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              commit;
   logic              in_range;
   logic [WORD_W-1:0] wword;
   logic [WORD_W-1:0] rword;

   // With zero wait states the commit happens on the capture edge, so use live inputs.
   always_comb begin
      sel_we    = lat_we;
      sel_addr  = lat_addr;
      sel_wdata = lat_wdata;
      commit    = 1'b0;
      if (state == DMEM_IDLE) begin
         sel_we    = we;
         sel_addr  = addr;
         sel_wdata = wdata;
      end
      if (WAIT_STATES == 0) commit = rst && (state == DMEM_IDLE) && req;
      else                  commit = rst && (state == DMEM_WAIT) && (cnt == 4'd0);
   end

   generate
      if (DEPTH >= (2 ** ADDR_W)) begin : g_full
         assign in_range = 1'b1;
      end else begin : g_part
         localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
         assign in_range = ({1'b0, sel_addr} < DEPTH_L);
      end
   endgenerate

`ifdef DMEM_PARITY_EN
   assign wword = {^sel_wdata, sel_wdata};
`else
   assign wword = sel_wdata;
`endif

   dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_arr (
      .clk   (clk),
      .rst   (rst),
      .we    (commit & sel_we & in_range),
      .re    (commit & ~sel_we),
      .zero  (~in_range),
      .idx   (sel_addr[IDX_W-1:0]),
      .wword (wword),
      .rword (rword)
   );

   assign rdata     = rword[DATA_W-1:0];
   assign busy      = (state != DMEM_IDLE);
   assign dbg_state = state;

   // ack and par_err are registered from DONE, so they appear in the cycle after DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= DMEM_IDLE;
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         ack       <= 1'b0;
`ifdef DMEM_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         ack <= (state == DMEM_DONE);
`ifdef DMEM_PARITY_EN
         par_err <= (state == DMEM_DONE) && !lat_we &&
                    (rword[DATA_W] != ^rword[DATA_W-1:0]);
`endif
         case (state)
            DMEM_IDLE: begin
               if (req) begin
                  lat_we    <= we;
                  lat_addr  <= addr;
                  lat_wdata <= wdata;
                  if (WAIT_STATES == 0) begin
                     state <= DMEM_DONE;
                  end else begin
                     state <= DMEM_WAIT;
                     cnt   <= 4'(WAIT_STATES - 1);
                  end
               end
            end
            DMEM_WAIT: begin
               if (cnt != 4'd0) cnt   <= cnt - 4'd1;
               else             state <= DMEM_DONE;
            end
            DMEM_DONE: state <= DMEM_IDLE;
            default:   state <= DMEM_IDLE;
         endcase
      end
   end

`ifndef DMEM_PARITY_EN
   assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: four instances with different WAIT_STATES/DEPTH share data inputs,
// each with its own req. Define DMEM_PARITY_EN to also exercise the parity path.
module tb_dmem_ctrl;
   import dmem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'b0;
   logic        we = 1'b0;
   logic [7:0]  addr = 8'h00;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  rdata [4];
   logic [3:0]  ack, busy, perr;
   dmem_state_e st [4];

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q [$];
   logic [7:0] model [4][256];
   logic [7:0] last_rd [4];

   always #5 clk = ~clk;

   dmem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(1)) u0 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .par_err(perr[0]), .dbg_state(st[0]));
   dmem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u1 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .par_err(perr[1]), .dbg_state(st[1]));
   dmem_ctrl #(.ADDR_W(8), .DEPTH(128), .WAIT_STATES(1)) u2 (
      .clk(clk), .rst(rst), .req(req[2]), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2]), .par_err(perr[2]), .dbg_state(st[2]));
   dmem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) u3 (
      .clk(clk), .rst(rst), .req(req[3]), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata[3]), .ack(ack[3]), .busy(busy[3]), .par_err(perr[3]), .dbg_state(st[3]));

   function automatic int dep(input int i);
      return (i == 2) ? 128 : 256;
   endfunction

   function automatic int ws(input int i);
      case (i)
         1:       return 0;
         3:       return 3;
         default: return 1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access on instance idx: checks busy after capture, ack latency, data and pulse width.
   task automatic access(input int idx, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic pe);
      int n;
      logic [7:0] exp_rd;
      @(negedge clk);
      req[idx] = 1'b1; we = w; addr = a; wdata = d;
      if (!w) exp_q.push_back((int'(a) < dep(idx)) ? model[idx][a] : 8'h00);
      @(posedge clk);
      #1 chk("busy_after_capture", 32'(busy[idx]), 32'd1);
      @(negedge clk);
      req[idx] = 1'b0; we = ~w; addr = ~a; wdata = ~d;
      n = 0;
      while (!ack[idx] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ack_latency", 32'(n), 32'(1 + ws(idx)));
      if (ack[idx]) begin
         if (!w) begin
            exp_rd = exp_q.pop_front();
            chk("rdata", 32'(rdata[idx]), 32'(exp_rd));
            last_rd[idx] = exp_rd;
         end else begin
            chk("rdata_hold_on_write", 32'(rdata[idx]), 32'(last_rd[idx]));
            if (int'(a) < dep(idx)) model[idx][a] = d;
         end
         chk("par_err_with_ack", 32'(perr[idx]), 32'(pe));
         @(negedge clk);
         chk("ack_one_cycle", 32'(ack[idx]), 32'd0);
         chk("par_err_one_cycle", 32'(perr[idx]), 32'd0);
      end
   endtask

   initial begin
      int i;
      logic [7:0] rd [6];
      for (int k = 0; k < 4; k++) last_rd[k] = 8'h00;

      // Reset, asserted away from a clock edge, takes effect immediately.
      #2 rst = 1'b0;
      #1;
      chk("reset_ack", 32'(ack), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_rdata0", 32'(rdata[0]), 32'h00);
      chk("reset_state0", 32'(st[0]), 32'(DMEM_IDLE));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("idle_ack", 32'(ack), 32'h0);
         chk("idle_busy", 32'(busy), 32'h0);
      end

      // One wait state: write then read back.
      access(0, 1'b1, 8'h10, 8'hA5, 1'b0);
      access(0, 1'b0, 8'h10, 8'h00, 1'b0);

      // Mid-clock reset clears rdata without a clock edge.
      @(posedge clk);
      #3 rst = 1'b0;
      #1 chk("midclk_reset_rdata", 32'(rdata[0]), 32'h00);
      chk("midclk_reset_busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) last_rd[k] = 8'h00;

      // Zero wait states, req held high: an ack every second cycle.
      @(negedge clk);
      req[1] = 1'b1; we = 1'b1; addr = 8'h00; wdata = 8'hC0;
      i = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("b2b_ack", 32'(ack[1]), 32'(c % 2));
         if (ack[1]) begin
            model[1][i] = 8'hC0 + 8'(i);
            i++;
            addr = 8'(i); wdata = 8'hC0 + 8'(i);
         end
      end
      req[1] = 1'b0;
      chk("b2b_ack_count", 32'(i), 32'd4);
      for (int k = 0; k < 4; k++) access(1, 1'b0, 8'(k), 8'h00, 1'b0);

      // Out-of-range on a 128-word array.
      access(2, 1'b1, 8'h80, 8'h55, 1'b0);
      access(2, 1'b0, 8'h80, 8'h00, 1'b0);
      access(2, 1'b1, 8'h7F, 8'h7F, 1'b0);
      access(2, 1'b0, 8'h7F, 8'h00, 1'b0);

      // Reset one cycle after capture with three wait states: write is abandoned.
      access(3, 1'b1, 8'h20, 8'h11, 1'b0);
      @(negedge clk);
      req[3] = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      req[3] = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("abort_busy", 32'(busy[3]), 32'd0);
      chk("abort_state", 32'(st[3]), 32'(DMEM_IDLE));
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_ack", 32'(ack[3]), 32'd0);
      end
      rst = 1'b1;
      for (int k = 0; k < 4; k++) last_rd[k] = 8'h00;
      access(3, 1'b0, 8'h20, 8'h00, 1'b0);

      // Random data, written then read back in reverse order.
      for (int k = 0; k < 6; k++) begin
         rd[k] = 8'($urandom_range(0, 255));
         access(0, 1'b1, 8'h40 + 8'(k), rd[k], 1'b0);
      end
      for (int k = 5; k >= 0; k--) access(0, 1'b0, 8'h40 + 8'(k), 8'h00, 1'b0);

`ifdef DMEM_PARITY_EN
      access(0, 1'b1, 8'h30, 8'h3C, 1'b0);
      access(0, 1'b1, 8'h31, 8'h3D, 1'b0);
      u0.u_arr.mem[8'h30] = {~(^8'h3C), 8'h3C};
      access(0, 1'b0, 8'h30, 8'h00, 1'b1);
      access(0, 1'b0, 8'h31, 8'h00, 1'b0);
`endif

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
